// File: rtl/mul_div_unit_if.sv
// Issue/writeback bundle for the iterative multiply/divide unit.
// master = issue stage and write mux, slave = the unit.
interface mul_div_unit_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 2
);
    logic              start;
    logic              op_div;
    logic [WIDTH-1:0]  src_a;
    logic [WIDTH-1:0]  src_b;
    logic [ADDR_W-1:0] dest;
    logic              flush;
    logic              wb_grant;
    logic              busy;
    logic              wb_wen;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;

    modport master (
        output start, op_div, src_a, src_b, dest, flush, wb_grant,
        input  busy, wb_wen, wb_addr, wb_data
    );

    modport slave (
        input  start, op_div, src_a, src_b, dest, flush, wb_grant,
        output busy, wb_wen, wb_addr, wb_data
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock.
// Define MUL_DIV_UNIT_DIV_EN to build the divider; otherwise every op multiplies.
module mul_div_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 2
) (
    input  logic          clk,
    input  logic          resetn,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  acc_nxt;
    logic [2*WIDTH-1:0]  mul_nxt;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH-1:0]    opa;
    logic [ADDR_W-1:0]   dst;
    logic                accept;
    logic                last;
    logic                wen;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic [WIDTH-1:0]    opb;
    logic                is_div;
    logic [2*WIDTH-1:0]  div_nxt;
    logic [WIDTH:0]      rem_sh;
    logic [WIDTH+1:0]    diff;
`else
    logic                unused_op_div;
    assign unused_op_div = bus.op_div;
`endif

    assign accept = (state == IDLE) && bus.start && !bus.flush;
    assign last   = (state == RUN) && (cnt == CW'(1));

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state and write enable; flush overrides everything.
    always_comb begin
        state_nxt = state;
        wen       = 1'b0;
        unique case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (last) state_nxt = (dst == '0) ? IDLE : WB;
            WB: begin
                if (bus.wb_grant) begin
                    wen       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
            wen       = 1'b0;
        end
    end

    // One iteration step: acc = {high, low}, low holds the multiplier
    // (multiply) or dividend/quotient (divide).
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
        mul_nxt = {mul_sum, acc[WIDTH-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = {1'b0, rem_sh} - {2'b00, opb};
        if (!diff[WIDTH+1])
            div_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        acc_nxt = is_div ? div_nxt : mul_nxt;
`else
        acc_nxt = mul_nxt;
`endif
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            acc     <= '0;
            opa     <= '0;
            dst     <= '0;
            bus.wb_addr <= '0;
            bus.wb_data <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
            opb     <= '0;
            is_div  <= 1'b0;
`endif
        end else if (accept) begin
            cnt <= CW'(WIDTH);
            opa <= bus.src_a;
            dst <= bus.dest;
`ifdef MUL_DIV_UNIT_DIV_EN
            opb    <= bus.src_b;
            is_div <= bus.op_div;
            acc    <= {{WIDTH{1'b0}}, bus.op_div ? bus.src_a : bus.src_b};
`else
            acc <= {{WIDTH{1'b0}}, bus.src_b};
`endif
        end else if (state == RUN && !bus.flush) begin
            cnt <= cnt - CW'(1);
            acc <= acc_nxt;
            if (last) begin
                bus.wb_addr <= dst;
                bus.wb_data <= acc_nxt[WIDTH-1:0];
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.wb_wen = wen;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, stall, $zero dest,
// ignored restart, flush, async reset and (optionally) division.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mul_div_unit_if #(.WIDTH(16), .ADDR_W(2)) bus ();

    mul_div_unit #(.WIDTH(16), .ADDR_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0: present operands, check idle, accept on the edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] d, input logic div);
        bus.start  = 1'b1;
        bus.src_a  = a;
        bus.src_b  = b;
        bus.dest   = d;
        bus.op_div = div;
        #1;
        chk("idle_at_issue", {31'd0, bus.busy}, 32'd0);
        tick();
        bus.start = 1'b0;
        bus.src_a = 16'hDEAD;
        bus.src_b = 16'hBEEF;
        bus.dest  = 2'd0;
    endtask

    // Cycles 1..16: busy, no write.
    task automatic run16(input string tag);
        for (int c = 1; c <= 16; c++) begin
            #1;
            chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            chk({tag, "_nowen"}, {31'd0, bus.wb_wen}, 32'd0);
            tick();
        end
    endtask

    task automatic full_op(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] d,
                           input logic div, input logic [15:0] exp);
        bus.wb_grant = 1'b1;
        issue(a, b, d, div);
        run16(tag);
        #1;
        chk({tag, "_wen17"}, {31'd0, bus.wb_wen}, 32'd1);
        chk({tag, "_addr17"}, {30'd0, bus.wb_addr}, {30'd0, d});
        chk({tag, "_data17"}, {16'd0, bus.wb_data}, {16'd0, exp});
        tick();
        #1;
        chk({tag, "_idle18"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.op_div   = 1'b0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.dest     = '0;
        bus.flush    = 1'b0;
        bus.wb_grant = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_wen", {31'd0, bus.wb_wen}, 32'd0);
        chk("rst_addr", {30'd0, bus.wb_addr}, 32'd0);
        chk("rst_data", {16'd0, bus.wb_data}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // 1: 3*5 -> 15 at cycle 17, idle at 18
        full_op("t1", 16'd3, 16'd5, 2'd1, 1'b0, 16'd15);
        #1;
        chk("t1_wen18", {31'd0, bus.wb_wen}, 32'd0);
        chk("t1_hold18", {16'd0, bus.wb_data}, 32'd15);
        tick();

        // 2: FFFF*FFFF low half, write stalled cycles 17..19
        bus.wb_grant = 1'b0;
        issue(16'hFFFF, 16'hFFFF, 2'd2, 1'b0);
        run16("t2");
        for (int c = 17; c <= 19; c++) begin
            #1;
            chk("t2_stall_wen", {31'd0, bus.wb_wen}, 32'd0);
            chk("t2_stall_busy", {31'd0, bus.busy}, 32'd1);
            chk("t2_stall_addr", {30'd0, bus.wb_addr}, 32'd2);
            chk("t2_stall_data", {16'd0, bus.wb_data}, 32'h0001);
            tick();
        end
        bus.wb_grant = 1'b1;
        #1;
        chk("t2_wen20", {31'd0, bus.wb_wen}, 32'd1);
        chk("t2_data20", {16'd0, bus.wb_data}, 32'h0001);
        tick();
        #1;
        chk("t2_idle21", {31'd0, bus.busy}, 32'd0);
        tick();

        // 3: dest $zero, restart in cycle 5 ignored
        issue(16'd7, 16'd9, 2'd0, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            if (c == 5) begin
                bus.start = 1'b1;
                bus.src_a = 16'd2;
                bus.src_b = 16'd2;
                bus.dest  = 2'd1;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            chk("t3_busy", {31'd0, bus.busy}, 32'd1);
            chk("t3_nowen", {31'd0, bus.wb_wen}, 32'd0);
            tick();
        end
        bus.start = 1'b0;
        #1;
        chk("t3_idle17", {31'd0, bus.busy}, 32'd0);
        chk("t3_nowen17", {31'd0, bus.wb_wen}, 32'd0);
        chk("t3_result", {16'd0, bus.wb_data}, 32'd63);
        tick();
        #1;
        chk("t3_nowen18", {31'd0, bus.wb_wen}, 32'd0);
        tick();

        // 4a: flush in cycle 8
        issue(16'd10, 16'd10, 2'd1, 1'b0);
        for (int c = 1; c <= 7; c++) tick();
        bus.flush = 1'b1;
        #1;
        chk("t4_flush_wen", {31'd0, bus.wb_wen}, 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("t4_idle9", {31'd0, bus.busy}, 32'd0);
        for (int c = 9; c <= 20; c++) begin
            #1;
            chk("t4_nowen", {31'd0, bus.wb_wen}, 32'd0);
            tick();
        end
        chk("t4_data_kept", {16'd0, bus.wb_data}, 32'd63);

        // 4b: async reset in cycle 10
        issue(16'd4, 16'd4, 2'd2, 1'b0);
        for (int c = 1; c <= 9; c++) tick();
        resetn = 1'b0;
        #1;
        chk("t4_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("t4_rst_wen", {31'd0, bus.wb_wen}, 32'd0);
        chk("t4_rst_addr", {30'd0, bus.wb_addr}, 32'd0);
        chk("t4_rst_data", {16'd0, bus.wb_data}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t4_rst_nowen", {31'd0, bus.wb_wen}, 32'd0);
        end

        // 5: division or multiply-only fallback
`ifdef MUL_DIV_UNIT_DIV_EN
        full_op("t5_div", 16'd100, 16'd7, 2'd3, 1'b1, 16'd14);
        tick();
        full_op("t5_div0", 16'd1234, 16'd0, 2'd1, 1'b1, 16'hFFFF);
        tick();
        full_op("t5_mul", 16'd6, 16'd7, 2'd2, 1'b0, 16'd42);
`else
        full_op("t5_nodiv", 16'd6, 16'd7, 2'd3, 1'b1, 16'd42);
`endif
        tick();
        full_op("t6_mul", 16'h1234, 16'h0010, 2'd1, 1'b0, 16'h2340);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
